// File: rtl/alu_op_sequencer.sv
// Clocked, handshaked driver for a combinational single-cycle ALU.
// It issues one operation, waits SETTLE cycles, then returns R/Overflow/Zero with the caller's tag.
// Optional macro ALU_OVF_STICKY_EN adds the ovf_clr/ovf_sticky overflow flag.
module alu_op_sequencer #(
  parameter int WIDTH  = 32,
  parameter int CTR_W  = 3,
  parameter int TAG_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  input  logic [CTR_W-1:0] req_ctr,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [CTR_W-1:0] alu_ctr,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [15:0]      op_count
`ifdef ALU_OVF_STICKY_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`endif
);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("alu_op_sequencer: SETTLE must be in 1..15");
    end
  endgenerate

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             ovf;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [TAG_W-1:0] tag_q;
  rsp_t             rsp_q;
  logic             capture;

  // Handshake readiness comes from state alone so req_ready never depends on req_valid.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign capture   = (state == DRIVE) && (cnt == 4'd0);

  assign rsp_r        = rsp_q.r;
  assign rsp_overflow = rsp_q.ovf;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_tag      = rsp_q.tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      tag_q     <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
      alu_ctr   <= '0;
      rsp_q     <= '0;
      rsp_valid <= 1'b0;
      op_count  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_x   <= req_x;
            alu_y   <= req_y;
            alu_ctr <= req_ctr;
            tag_q   <= req_tag;
            cnt     <= 4'(SETTLE - 1);
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == 4'd0) begin
            rsp_q     <= '{r: alu_r, ovf: alu_overflow, zero: alu_zero, tag: tag_q};
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // A request is deliberately not taken here, even while the response retires.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_OVF_STICKY_EN
  // A capture with overflow wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst)                         ovf_sticky <= 1'b0;
    else if (capture && alu_overflow) ovf_sticky <= 1'b1;
    else if (ovf_clr)                ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: SETTLE=1 instance with an ALU model, SETTLE=3 instance with scripted ALU outputs.
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SETTLE=1 instance
  logic        rst1, rv1, rr1, rdy1, rsv1, ao1, az1, ro1, rz1, busy1;
  logic [31:0] x1, y1, ax1, ay1, ar1, rr_1;
  logic [2:0]  c1, ac1;
  logic [3:0]  t1, rt1;
  logic [15:0] cnt1;
  logic        clr1, stk1;
  logic [32:0] sum1;

  // Bench ALU model: 001 add, 111 sub, otherwise AND.
  always_comb begin
    sum1 = 33'd0;
    ao1  = 1'b0;
    case (ac1)
      3'b001: begin
        sum1 = {1'b0, ax1} + {1'b0, ay1};
        ao1  = (ax1[31] == ay1[31]) && (sum1[31] != ax1[31]);
      end
      3'b111: begin
        sum1 = {1'b0, ax1} - {1'b0, ay1};
        ao1  = (ax1[31] != ay1[31]) && (sum1[31] != ax1[31]);
      end
      default: sum1 = {1'b0, ax1 & ay1};
    endcase
    ar1 = sum1[31:0];
    az1 = (ar1 == 32'd0);
  end

  alu_op_sequencer #(.WIDTH(32), .CTR_W(3), .TAG_W(4), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst1), .req_valid(rv1), .req_ready(rdy1),
    .req_x(x1), .req_y(y1), .req_ctr(c1), .req_tag(t1),
    .alu_x(ax1), .alu_y(ay1), .alu_ctr(ac1),
    .alu_r(ar1), .alu_overflow(ao1), .alu_zero(az1),
    .rsp_valid(rsv1), .rsp_ready(rr1), .rsp_r(rr_1), .rsp_overflow(ro1),
    .rsp_zero(rz1), .rsp_tag(rt1), .busy(busy1), .op_count(cnt1)
`ifdef ALU_OVF_STICKY_EN
    , .ovf_clr(clr1), .ovf_sticky(stk1)
`endif
  );

  // SETTLE=3 instance
  logic        rst3, rv3, rr3, rdy3, rsv3, o3, z3, ro3, rz3, busy3;
  logic [31:0] x3, y3, ax3, ay3, r3, rr_3;
  logic [2:0]  c3, ac3;
  logic [3:0]  t3, rt3;
  logic [15:0] cnt3;
  logic        clr3, stk3;

  alu_op_sequencer #(.WIDTH(32), .CTR_W(3), .TAG_W(4), .SETTLE(3)) u3 (
    .clk(clk), .rst(rst3), .req_valid(rv3), .req_ready(rdy3),
    .req_x(x3), .req_y(y3), .req_ctr(c3), .req_tag(t3),
    .alu_x(ax3), .alu_y(ay3), .alu_ctr(ac3),
    .alu_r(r3), .alu_overflow(o3), .alu_zero(z3),
    .rsp_valid(rsv3), .rsp_ready(rr3), .rsp_r(rr_3), .rsp_overflow(ro3),
    .rsp_zero(rz3), .rsp_tag(rt3), .busy(busy3), .op_count(cnt3)
`ifdef ALU_OVF_STICKY_EN
    , .ovf_clr(clr3), .ovf_sticky(stk3)
`endif
  );

  // One full operation on u1 with rsp_ready high: accept, capture, retire.
  task automatic op1(input logic [31:0] x, input logic [31:0] y, input logic [2:0] c, input logic [3:0] t);
    rv1 = 1'b1; x1 = x; y1 = y; c1 = c; t1 = t;
    tick();
    rv1 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst1 = 1'b1; rv1 = 1'b0; rr1 = 1'b0; x1 = '0; y1 = '0; c1 = '0; t1 = '0; clr1 = 1'b0;
    rst3 = 1'b1; rv3 = 1'b0; rr3 = 1'b0; x3 = '0; y3 = '0; c3 = '0; t3 = '0; clr3 = 1'b0;
    r3 = 32'd1; o3 = 1'b0; z3 = 1'b0;
    stk1 = 1'b0; stk3 = 1'b0;
    tick(); tick();
    rst1 = 1'b0; rst3 = 1'b0;

    // Reset state
    chk("rst_req_ready", 64'(rdy1), 64'd1);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_rsp_valid", 64'(rsv1), 64'd0);
    chk("rst_op_count", 64'(cnt1), 64'd0);
    chk("rst_alu_x", 64'(ax1), 64'd0);
    chk("rst_rsp_r", 64'(rr_1), 64'd0);

    // Reset while in DRIVE abandons the operation
    rv1 = 1'b1; x1 = 32'h60000000; y1 = 32'h10000000; c1 = 3'b111; t1 = 4'h5;
    tick();
    chk("drv_busy", 64'(busy1), 64'd1);
    chk("drv_alu_ctr", 64'(ac1), 64'h7);
    rv1 = 1'b0; rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk("midrst_rsp_valid", 64'(rsv1), 64'd0);
    chk("midrst_alu_x", 64'(ax1), 64'd0);
    chk("midrst_req_ready", 64'(rdy1), 64'd1);
    chk("midrst_op_count", 64'(cnt1), 64'd0);

    // SETTLE=1 add with overflow
    rr1 = 1'b1;
    rv1 = 1'b1; x1 = 32'h80000000; y1 = 32'hF0000000; c1 = 3'b001; t1 = 4'h3;
    tick();
    rv1 = 1'b0;
    chk("s1_accept_alu_x", 64'(ax1), 64'h80000000);
    chk("s1_accept_alu_y", 64'(ay1), 64'hF0000000);
    chk("s1_accept_rsp_valid", 64'(rsv1), 64'd0);
    chk("s1_accept_req_ready", 64'(rdy1), 64'd0);
    tick();
    chk("s1_rsp_valid", 64'(rsv1), 64'd1);
    chk("s1_rsp_r", 64'(rr_1), 64'h70000000);
    chk("s1_rsp_ovf", 64'(ro1), 64'd1);
    chk("s1_rsp_zero", 64'(rz1), 64'd0);
    chk("s1_rsp_tag", 64'(rt1), 64'h3);
    tick();
    chk("s1_retire_valid", 64'(rsv1), 64'd0);
    chk("s1_op_count", 64'(cnt1), 64'd1);
    chk("s1_retire_ready", 64'(rdy1), 64'd1);
    chk("s1_hold_rsp_r", 64'(rr_1), 64'h70000000);
    chk("s1_hold_alu_x", 64'(ax1), 64'h80000000);

    // Subtract producing zero
    op1(32'h12345678, 32'h12345678, 3'b111, 4'h9);
    chk("sub_rsp_r", 64'(rr_1), 64'd0);
    chk("sub_rsp_zero", 64'(rz1), 64'd1);
    chk("sub_rsp_tag", 64'(rt1), 64'h9);
    chk("sub_op_count", 64'(cnt1), 64'd2);

    // op_count wrap
    force u1.op_count = 16'hFFFE;
    tick();
    release u1.op_count;
    op1(32'hFF00FF00, 32'h0F0F0F0F, 3'b010, 4'h1);
    chk("and_rsp_r", 64'(rr_1), 64'h0F000F00);
    chk("wrap_pre", 64'(cnt1), 64'hFFFF);
    op1(32'h1, 32'h1, 3'b001, 4'h2);
    chk("wrap_post", 64'(cnt1), 64'h0000);

`ifdef ALU_OVF_STICKY_EN
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("stk_cleared", 64'(stk1), 64'd0);
    clr1 = 1'b1;
    rv1 = 1'b1; x1 = 32'h7FFFFFFF; y1 = 32'h00000001; c1 = 3'b001; t1 = 4'h4;
    tick();
    rv1 = 1'b0;
    tick();
    chk("stk_set_wins", 64'(stk1), 64'd1);
    clr1 = 1'b0;
    tick();
    chk("stk_hold", 64'(stk1), 64'd1);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("stk_clr_alone", 64'(stk1), 64'd0);
`endif

    // SETTLE=3: ALU output changes during the settle window, then back-pressure
    rv3 = 1'b1; x3 = 32'h5; y3 = 32'h6; c3 = 3'b010; t3 = 4'hA;
    tick();
    x3 = 32'h9; t3 = 4'hB;
    tick();
    tick();
    chk("s3_not_yet", 64'(rsv3), 64'd0);
    r3 = 32'h0; z3 = 1'b1;
    tick();
    chk("s3_rsp_valid", 64'(rsv3), 64'd1);
    chk("s3_rsp_r", 64'(rr_3), 64'd0);
    chk("s3_rsp_zero", 64'(rz3), 64'd1);
    chk("s3_rsp_tag", 64'(rt3), 64'hA);
    r3 = 32'h55; z3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", 64'(rsv3), 64'd1);
      chk("bp_rsp_r", 64'(rr_3), 64'd0);
      chk("bp_req_ready", 64'(rdy3), 64'd0);
      chk("bp_alu_x", 64'(ax3), 64'h5);
    end
    rr3 = 1'b1;
    tick();
    chk("bp_retire_valid", 64'(rsv3), 64'd0);
    chk("bp_retire_ready", 64'(rdy3), 64'd1);
    chk("bp_op_count", 64'(cnt3), 64'd1);
    chk("bp_no_accept_in_resp", 64'(ax3), 64'h5);
    tick();
    rv3 = 1'b0;
    chk("bp_next_alu_x", 64'(ax3), 64'h9);
    chk("bp_next_busy", 64'(busy3), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side driver for the combinational single-cycle ALU (X, Y, ALUctr -> R, Overflow, Zero).
- Accepts one operation request over a valid/ready handshake and drives the ALU operand and control lines from registers.
- Waits a fixed settle time, then captures R/Overflow/Zero and returns them with the request tag over a second valid/ready handshake.
- Sits between the CPU datapath or test controller and the ALU; replaces ad-hoc timed stimulus with a clocked, handshaked interface.

Parameters:
WIDTH, 32, operand/result width
CTR_W, 3, ALU control width
TAG_W, 4, request tag width
SETTLE, 1, cycles between driving alu_* and capturing results; legal 1..15; elaboration error outside this range

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept
req_x  in  WIDTH  operand X
req_y  in  WIDTH  operand Y
req_ctr  in  CTR_W  ALU control code, passed through unmodified
req_tag  in  TAG_W  caller tag
alu_x  out  WIDTH  to ALU X
alu_y  out  WIDTH  to ALU Y
alu_ctr  out  CTR_W  to ALU ALUctr
alu_r  in  WIDTH  from ALU R
alu_overflow  in  1  from ALU Overflow
alu_zero  in  1  from ALU Zero
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_r  out  WIDTH  captured R
rsp_overflow  out  1  captured Overflow
rsp_zero  out  1  captured Zero
rsp_tag  out  TAG_W  tag of the request
busy  out  1  state != IDLE
op_count  out  16  completed-operation counter

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: state IDLE; alu_x, alu_y, alu_ctr, rsp_r, rsp_tag, op_count all 0; rsp_valid, rsp_overflow, rsp_zero, busy 0. req_ready is 1 in the first cycle after reset.
- FSM states: IDLE, DRIVE, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready at an edge:
    - alu_x/alu_y/alu_ctr <= req_x/req_y/req_ctr
    - tag latched internally
    - settle counter <= SETTLE-1
    - go to DRIVE
  - DRIVE: req_ready=0. Counter decrements each edge. At the edge where the counter is 0:
    - rsp_r/rsp_overflow/rsp_zero <= alu_r/alu_overflow/alu_zero
    - rsp_tag <= latched tag
    - rsp_valid <= 1
    - go to RESP
  - RESP: req_ready=0. rsp_* held stable while rsp_valid && !rsp_ready. On rsp_ready at an edge:
    - rsp_valid <= 0
    - op_count <= op_count+1
    - go to IDLE
- Latency: request accepted at edge N -> rsp_valid high after edge N+SETTLE.
- Throughput: minimum SETTLE+2 cycles per operation with rsp_ready tied high. No request is accepted in RESP, even in the cycle rsp_ready is high.
- alu_x/alu_y/alu_ctr hold the last issued values in IDLE and RESP; they change only on request acceptance.
- rsp_r/rsp_overflow/rsp_zero/rsp_tag keep their last values after rsp_valid falls.
- req_ready and busy are decoded from state only. They are never combinationally dependent on req_valid or rsp_ready.
- op_count wraps 16'hFFFF -> 16'h0000.
- Reset mid-operation (DRIVE or RESP): operation abandoned, no response issued, op_count not incremented, all outputs to reset values.
- The block does not interpret req_ctr. Unused or illegal ALU codes are forwarded and their results returned as-is.

Optional Feature:
Macro ALU_OVF_STICKY_EN.
- Defined: adds ports ovf_clr (in, 1) and ovf_sticky (out, 1).
  - ovf_sticky reset 0.
  - Set at the capture edge when alu_overflow=1.
  - Cleared at an edge with ovf_clr=1.
  - If capture-with-overflow and ovf_clr occur at the same edge, ovf_sticky ends at 1 (set wins).
- Undefined: both ports absent; no sticky logic.

Test Plan:
- SETTLE=1, rsp_ready=1, request x=32'h80000000 y=32'hF0000000 ctr=3'b001 tag=4'h3; bench ALU model returns R=32'h70000000 ovf=1 zero=0 -> rsp_valid high exactly 1 cycle after acceptance with rsp_r=32'h70000000 rsp_overflow=1 rsp_zero=0 rsp_tag=4'h3; op_count 0->1.
- SETTLE=3, ALU model changes alu_r from 32'h1 to 32'h0 (zero=1) two cycles after drive -> captured rsp_r=0 rsp_zero=1; rsp_valid rises 3 cycles after acceptance.
- Back-pressure: rsp_ready=0 for 5 cycles, req_valid held high with a new request -> rsp_* stable, req_ready=0 throughout; after rsp_ready=1, next request accepted in the following IDLE cycle.
- Reset asserted in DRIVE with req x=32'h60000000 y=32'h10000000 ctr=3'b111 -> next cycle: rsp_valid=0, alu_x=0, req_ready=1, op_count unchanged (0).
- op_count preloaded by 65535 completed ops (or forced) -> one more completion wraps op_count to 16'h0000.
- ALU_OVF_STICKY_EN defined: an overflow capture coincident with ovf_clr=1 -> ovf_sticky=1; then ovf_clr=1 alone -> ovf_sticky=0.
